r_muladd: RTL and testbench

R_MULADD -- requirements
Module: r_muladd

---
 rtl/pea_pkg.sv | 13 +
 rtl/r_mul_core.sv | 60 ++++++
 rtl/r_muladd.sv | 137 +++++++++++++
 tb/tb_r_muladd.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pea_pkg.sv
// Shared definitions for the pea arithmetic blocks: default datapath width and
// the r_muladd controller state encoding.
package pea_pkg;

  localparam int N_BITS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2
  } rmul_state_t;

endpackage : pea_pkg

// File: rtl/r_mul_core.sv
// Radix-2 unsigned shift-add multiplier: one partial product per cycle,
// always exactly N steps regardless of operand values.
module r_mul_core #(
  parameter int N = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic [2*N-1:0]   prod,
  output logic             done
);

  localparam int CW = $clog2(N) + 1;

  logic [CW-1:0]  cnt;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic           run;

  // done marks the cycle whose closing edge performs the final step
  assign done = run && (cnt == CW'(N - 1));
  assign prod = acc;

  // Accumulator, multiplicand/multiplier shifters and step counter
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= {(2*N){1'b0}};
      mcand  <= {(2*N){1'b0}};
      mplier <= {N{1'b0}};
      cnt    <= {CW{1'b0}};
      run    <= 1'b0;
    end else if (start) begin
      acc    <= {(2*N){1'b0}};
      mcand  <= {{N{1'b0}}, a};
      mplier <= b;
      cnt    <= {CW{1'b0}};
      run    <= 1'b1;
    end else if (run) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end else begin
        acc <= acc;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      run    <= !done;
    end else begin
      acc    <= acc;
      mcand  <= mcand;
      mplier <= mplier;
      cnt    <= cnt;
      run    <= run;
    end
  end

endmodule : r_mul_core

// File: rtl/r_muladd.sv
// Sequential q*d+r reconstruction (fixed N+1 cycle latency).
// Define RMUL_OVF_EN to enable the signed overflow flag on ovf_o.
module r_muladd
  import pea_pkg::*;
#(
  parameter int N = N_BITS
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic signed [N-1:0] q_i,
  input  logic signed [N-1:0] d_i,
  input  logic signed [N-1:0] r_i,
  output logic signed [N-1:0] p_o,
  output logic                valid_o,
  output logic                busy_o,
  output logic                ovf_o
);

  localparam int W = 2*N + 1;

  rmul_state_t         state;
  rmul_state_t         state_next;
  logic                sign;
  logic signed [N-1:0] rem;
  logic                start;
  logic                done;
  logic [2*N-1:0]      prod;
  logic [N-1:0]        q_mag;
  logic [N-1:0]        d_mag;
  logic [W-1:0]        prod_ext;
  logic [W-1:0]        prod_s;
  logic [W-1:0]        full;

  // -2^(N-1) wraps to itself, which is exactly its unsigned magnitude
  function automatic logic [N-1:0] mag(input logic [N-1:0] x);
    if (x[N-1]) begin
      mag = ~x + N'(1);
    end else begin
      mag = x;
    end
  endfunction

  assign q_mag = mag(q_i);
  assign d_mag = mag(d_i);
  assign start = (state == IDLE) && en_i;

  r_mul_core #(.N(N)) u_core (
    .clk   (clk_i),
    .rst   (rst_i),
    .start (start),
    .a     (q_mag),
    .b     (d_mag),
    .prod  (prod),
    .done  (done)
  );

  // Signed result in 2N+1 bits: no wrap is possible at this width
  always_comb begin
    prod_ext = {1'b0, prod};
    if (sign) begin
      prod_s = ~prod_ext + W'(1);
    end else begin
      prod_s = prod_ext;
    end
    full = prod_s + {{(N+1){rem[N-1]}}, rem};
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (en_i) begin
          state_next = MUL;
        end else begin
          state_next = IDLE;
        end
      end
      MUL: begin
        if (done) begin
          state_next = FIN;
        end else begin
          state_next = MUL;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, operand side-band and result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      sign    <= 1'b0;
      rem     <= {N{1'b0}};
      p_o     <= {N{1'b0}};
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      state   <= state_next;
      busy_o  <= (state_next != IDLE);
      valid_o <= (state == FIN);
      if (start) begin
        sign <= q_i[N-1] ^ d_i[N-1];
        rem  <= r_i;
      end else begin
        sign <= sign;
        rem  <= rem;
      end
      if (state == FIN) begin
        p_o <= full[N-1:0];
      end else begin
        p_o <= p_o;
      end
    end
  end

`ifdef RMUL_OVF_EN
  // Overflow when the wide result disagrees with sign-extended p_o
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_o <= 1'b0;
    end else if (state == FIN) begin
      ovf_o <= (full != {{(N+1){full[N-1]}}, full[N-1:0]});
    end else begin
      ovf_o <= ovf_o;
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^full[W-1:N];
  assign ovf_o     = 1'b0;
`endif

endmodule : r_muladd

// File: tb/tb_r_muladd.sv
// Directed self-checking bench for r_muladd at N=32.
module tb_r_muladd;

  localparam int N = 32;

  logic                clk;
  logic                rst;
  logic                en;
  logic signed [N-1:0] q;
  logic signed [N-1:0] d;
  logic signed [N-1:0] r;
  logic signed [N-1:0] p;
  logic                valid;
  logic                busy;
  logic                ovf;

  int n_checks;
  int n_fail;

  r_muladd #(.N(N)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (en),
    .q_i     (q),
    .d_i     (d),
    .r_i     (r),
    .p_o     (p),
    .valid_o (valid),
    .busy_o  (busy),
    .ovf_o   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation and watch 46 edges; lat = edge index of valid, -1 if none
  task automatic run_op(input logic [N-1:0] qv, input logic [N-1:0] dv, input logic [N-1:0] rv,
                        output logic [N-1:0] pv, output logic ov, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = -1;
    pv   = '0;
    ov   = 1'b0;
    q = qv; d = dv; r = rv; en = 1'b1;
    for (int e = 0; e < 46; e++) begin
      @(posedge clk); #1;
      if (e == 0) en = 1'b0;
      if (valid && !seen) begin
        seen = 1'b1;
        lat  = e;
        pv   = p;
        ov   = ovf;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; q = 32'd3; d = 32'd4; r = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    en = 1'b0;
    n_checks++; if (p !== 32'd0)  begin n_fail++; $display("FAIL reset_p got %h want 00000000", p); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (ovf !== 1'b0)   begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    q = 32'd7; d = 32'hFFFFFFFD; r = 32'd2; en = 1'b1;
    for (int e = 0; e <= 34; e++) begin
      @(posedge clk); #1;
      if (e == 0) en = 1'b0;
      if (e < 33) begin
        n_checks++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
          n_fail++; $display("FAIL basic_busy edge %0d got busy=%b valid=%b want busy=1 valid=0", e, busy, valid);
        end
      end else if (e == 33) begin
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", valid); end
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL basic_busy_end got %b want 0", busy); end
        n_checks++; if (p !== 32'hFFFFFFED) begin n_fail++; $display("FAIL basic_p got %h want ffffffed", p); end
        n_checks++; if (ovf !== 1'b0)   begin n_fail++; $display("FAIL basic_ovf got %b want 0", ovf); end
      end else begin
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse got %b want 0", valid); end
        n_checks++; if (p !== 32'hFFFFFFED) begin n_fail++; $display("FAIL basic_hold got %h want ffffffed", p); end
      end
    end
  endtask

  task automatic test_ovf();
    logic [N-1:0] pv;
    logic         ov;
    logic         exp_ovf;
    int           lat;
`ifdef RMUL_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    run_op(32'h80000000, 32'hFFFFFFFF, 32'd0, pv, ov, lat);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL ovf_latency got %0d want 33", lat); end
    n_checks++; if (pv !== 32'h80000000) begin n_fail++; $display("FAIL ovf_p got %h want 80000000", pv); end
    n_checks++; if (ov !== exp_ovf) begin n_fail++; $display("FAIL ovf_flag got %b want %b", ov, exp_ovf); end
  endtask

  task automatic test_back_to_back();
    int           nres;
    int           e1, e2;
    logic [N-1:0] p1, p2;
    nres = 0; e1 = -1; e2 = -1; p1 = '0; p2 = '0;
    for (int e = 0; e < 76; e++) begin
      if (e < 40) begin
        en = 1'b1; q = N'(e + 1); d = N'(e + 2); r = N'(e);
      end else begin
        en = 1'b0;
      end
      @(posedge clk); #1;
      if (valid) begin
        nres++;
        if (nres == 1) begin e1 = e; p1 = p; end
        if (nres == 2) begin e2 = e; p2 = p; end
      end
    end
    en = 1'b0;
    n_checks++; if (nres !== 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", nres); end
    n_checks++; if (e1 !== 33) begin n_fail++; $display("FAIL b2b_edge1 got %0d want 33", e1); end
    n_checks++; if (p1 !== 32'd2) begin n_fail++; $display("FAIL b2b_p1 got %h want 00000002", p1); end
    n_checks++; if (e2 !== 67) begin n_fail++; $display("FAIL b2b_edge2 got %0d want 67", e2); end
    n_checks++; if (p2 !== 32'd1294) begin n_fail++; $display("FAIL b2b_p2 got %h want 0000050e", p2); end
  endtask

  task automatic test_reset_mid();
    int npulse;
    npulse = 0;
    q = 32'd9; d = 32'd9; r = 32'd1; en = 1'b1;
    for (int e = 0; e < 46; e++) begin
      if (e == 1)  en = 1'b0;
      if (e == 10) rst = 1'b1;
      if (e == 11) rst = 1'b0;
      @(posedge clk); #1;
      if (e == 10 || e == 11) begin
        n_checks++;
        if (busy !== 1'b0 || p !== 32'd0 || valid !== 1'b0) begin
          n_fail++; $display("FAIL midrst edge %0d got busy=%b p=%h valid=%b want 0 0 0", e, busy, p, valid);
        end
      end
      if (valid) npulse++;
    end
    n_checks++; if (npulse !== 0) begin n_fail++; $display("FAIL midrst_pulse got %0d want 0", npulse); end
  endtask

  task automatic test_roundtrip();
    logic [N-1:0] pv;
    logic         ov;
    int           lat;
    run_op(32'hFFFFFF72, 32'd7, 32'hFFFFFFFA, pv, ov, lat);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL rt_latency got %0d want 33", lat); end
    n_checks++; if (pv !== 32'hFFFFFC18) begin n_fail++; $display("FAIL rt_p got %h want fffffc18", pv); end
    n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL rt_ovf got %b want 0", ov); end
  endtask

  task automatic test_zero();
    logic [N-1:0] pv;
    logic         ov;
    int           lat;
    run_op(32'd0, 32'd12345, 32'hFFFFFFFB, pv, ov, lat);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL zero_latency got %0d want 33", lat); end
    n_checks++; if (pv !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL zero_p got %h want fffffffb", pv); end
    n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL zero_ovf got %b want 0", ov); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; en = 1'b0; q = '0; d = '0; r = '0;
    test_reset();
    test_basic();
    test_ovf();
    test_back_to_back();
    test_reset_mid();
    test_roundtrip();
    test_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_r_muladd
